// File: rtl/param_atomic_controller.sv
// param_atomic_controller: command-driven register file controller that runs
// ALU operations through an external combinational ALU and performs an atomic
// compare-and-swap (CAS) between two registers.
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// cmd_ready=1; cmd_ready is high only in IDLE. The producer holds cmd_valid and
// cmd stable until that edge; no command is lost while the block is busy.
module param_atomic_controller #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 8,
    localparam int ADDR_W   = $clog2(REG_COUNT),
    localparam int CMD_W    = 3 + 3 * ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd,
    output logic [2:0]        alu_op_code,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] y,
    input  logic              Z,
    output logic              done,
    output logic              cas_success,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EXECUTE    = 3'd1,
        WRITE_BACK = 3'd2,
        CAS_CMP    = 3'd3,
        CAS_SWAP   = 3'd4
    } state_t;

    localparam logic [2:0] OP_CAS = 3'b111;
    localparam logic [2:0] OP_SUB = 3'b001;

    state_t state, state_nxt;

    logic [DATA_W-1:0] regs [REG_COUNT];

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] a1_q, a2_q, a3_q;
    logic              match_q;

    logic              accept;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_a1, cmd_a2, cmd_a3;

    assign cmd_op = cmd[CMD_W-1 -: 3];
    assign cmd_a1 = cmd[3*ADDR_W-1 -: ADDR_W];
    assign cmd_a2 = cmd[2*ADDR_W-1 -: ADDR_W];
    assign cmd_a3 = cmd[ADDR_W-1:0];

    assign accept    = cmd_valid && cmd_ready;
    assign rd_data   = regs[rd_addr];
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch all command fields on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a1_q <= '0;
            a2_q <= '0;
            a3_q <= '0;
        end else if (accept) begin
            op_q <= cmd_op;
            a1_q <= cmd_a1;
            a2_q <= cmd_a2;
            a3_q <= cmd_a3;
        end
    end

    // Capture the ALU zero flag as the CAS compare result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   match_q <= 1'b0;
        else if (state == CAS_CMP) match_q <= Z;
    end

    // Register file: ALU write-back on leaving EXECUTE, atomic swap on leaving
    // CAS_SWAP. With addr1==addr3 both swap writes carry the same value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (state == EXECUTE) begin
            regs[a3_q] <= y;
        end else if (state == CAS_SWAP && match_q) begin
            regs[a1_q] <= regs[a3_q];
            regs[a3_q] <= regs[a1_q];
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        cas_success = 1'b0;
        alu_op_code = '0;
        data_a      = '0;
        data_b      = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = (cmd_op == OP_CAS) ? CAS_CMP : EXECUTE;
            end
            EXECUTE: begin
                alu_op_code = op_q;
                data_a      = regs[a1_q];
                data_b      = regs[a2_q];
                state_nxt   = WRITE_BACK;
            end
            WRITE_BACK: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            CAS_CMP: begin
                alu_op_code = OP_SUB;
                data_a      = regs[a1_q];
                data_b      = regs[a2_q];
                state_nxt   = CAS_SWAP;
            end
            CAS_SWAP: begin
                done        = 1'b1;
                cas_success = match_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
